// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one memory data port among NCORES cores.
// A granted core holding lock keeps ownership (LOCKED) for read-modify-write sequences.
// Read results return RD_LAT cycles after the grant through a tag pipeline.
// Optional feature: define MEM_ARB_PERF_EN to build the saturating conflict counter.
module mem_arb #(
    parameter int unsigned NCORES = 2,
    parameter int unsigned AW     = 15,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES-1:0]    lock,
    input  logic [NCORES-1:0]    halt,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    rvalid,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        m_raddr,
    input  logic [DW-1:0]        m_rdata,
    output logic                 m_wen,
    output logic [AW-1:0]        m_waddr,
    output logic [DW-1:0]        m_wdata,
    output logic [31:0]          conflict_cnt
);

    localparam int unsigned PW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [0:0] {StArb, StLocked} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;      // last granted core; the owner while locked
    logic [NCORES-1:0] mreq, mlock;
    logic              win_vld;
    logic [PW-1:0]     win_idx;
    logic              rd_issue;
    logic [RD_LAT-1:0] tag_v_q;
    logic [PW-1:0]     tag_id_q [RD_LAT];

    // Halted cores are invisible to arbitration and lock handling.
    assign mreq  = req & ~halt;
    assign mlock = lock & ~halt;

    // Winner selection: only the owner when locked, else round robin from ptr+1.
    always_comb begin
        int            cand;
        logic [PW-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        win_vld  = 1'b0;
        win_idx  = '0;
        if (!reset) begin
            if (state_q == StLocked) begin
                win_vld = mreq[ptr_q];
                win_idx = ptr_q;
            end else begin
                for (int i = 1; i <= int'(NCORES); i++) begin
                    cand     = (int'(ptr_q) + i) % int'(NCORES);
                    cand_idx = PW'(cand);
                    if (!win_vld && mreq[cand_idx]) begin
                        win_vld = 1'b1;
                        win_idx = cand_idx;
                    end
                end
            end
        end
    end

    // Grant and memory port drive; a cycle carries either one read or one write.
    always_comb begin
        gnt      = '0;
        m_wen    = 1'b0;
        m_raddr  = '0;
        m_waddr  = '0;
        m_wdata  = '0;
        rd_issue = 1'b0;
        if (win_vld) begin
            gnt[win_idx] = 1'b1;
            if (we[win_idx]) begin
                m_wen   = 1'b1;
                m_waddr = addr[win_idx*AW +: AW];
                m_wdata = wdata[win_idx*DW +: DW];
            end else begin
                m_raddr  = addr[win_idx*AW +: AW];
                rd_issue = 1'b1;
            end
        end
    end

    // Next state: enter LOCKED on a locked grant, leave when the owner drops lock or halts.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (win_vld) begin
            ptr_d = win_idx;
        end
        unique case (state_q)
            StArb:    if (win_vld && mlock[win_idx]) state_d = StLocked;
            StLocked: if (!mlock[ptr_q]) state_d = StArb;
            default:  state_d = StArb;
        endcase
    end

    // State and pointer registers; reset leaves core 0 with first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StArb;
            ptr_q   <= PW'(NCORES - 1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Read tag pipeline: one slot per cycle of latency; reset drops all in-flight tags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_v_q[0]  <= rd_issue;
            tag_id_q[0] <= win_idx;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    // Read return: route memory data to the core whose tag reaches the pipeline end.
    always_comb begin
        rvalid = '0;
        if (tag_v_q[RD_LAT-1]) begin
            rvalid[tag_id_q[RD_LAT-1]] = 1'b1;
        end
        rdata = tag_v_q[RD_LAT-1] ? m_rdata : '0;
    end

`ifdef MEM_ARB_PERF_EN
    logic        multi;
    logic [31:0] cnt_q;

    assign multi        = ($countones(mreq) >= 2);
    assign conflict_cnt = cnt_q;

    // Saturating count of cycles with two or more unmasked requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (multi && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end
`else
    assign conflict_cnt = '0;
`endif

endmodule
